// File: rtl/reg_alloc_pkg.sv
// reg_alloc_ctrl shared types: opcodes, FSM states, default sizes.
// Optional HWM output enabled by REG_ALLOC_CTRL_HWM_EN.
package reg_alloc_pkg;

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_LBL_W    = 16;

  typedef enum logic [1:0] {
    OP_ALLOC = 2'd0,
    OP_FREE  = 2'd1,
    OP_LABEL = 2'd2,
    OP_FLUSH = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/reg_alloc_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from request vector.
// Pointer moves past the granted requester on advance.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_alloc_ctrl.sv
// LIFO register allocator with label counter and RR arbitration.
// Define REG_ALLOC_CTRL_HWM_EN to add the hwm high-water-mark output.
module reg_alloc_ctrl
  import reg_alloc_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int LBL_W    = DEF_LBL_W,
  localparam int RW = $clog2(NUM_REGS),
  localparam int DW = RW + 1,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [RW*NUM_REQ-1:0] req_reg,
  output logic [NUM_REQ-1:0]  req_ready,
  output logic                resp_valid,
  output logic [IW-1:0]       resp_id,
  output logic [LBL_W-1:0]    resp_data,
  output logic                resp_err,
`ifdef REG_ALLOC_CTRL_HWM_EN
  output logic [DW-1:0]       hwm,
`endif
  output logic [DW-1:0]       depth
);

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IW-1:0]      gid, gid_q;
  logic               advance;

  logic [DW-1:0]      depth_q, depth_d;
  logic [LBL_W-1:0]   lbl_q, lbl_d;
  logic [LBL_W-1:0]   data_d;
  logic               err_d;
  op_e                op;
  logic [RW-1:0]      rreg;

  assign advance = (state_q == S_IDLE) && (|req_valid);
  assign depth   = depth_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    gid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gid = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  if (|req_valid) state_d = S_GRANT;
      S_GRANT: begin
        req_ready = gnt_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Op fields are read while in GRANT; requesters hold them until accepted
  assign op   = op_e'(req_op[int'(gid_q)*2 +: 2]);
  assign rreg = req_reg[int'(gid_q)*RW +: RW];

  always_comb begin
    depth_d = depth_q;
    lbl_d   = lbl_q;
    data_d  = '0;
    err_d   = 1'b0;
    unique case (op)
      OP_ALLOC: begin
        if (depth_q == DW'(NUM_REGS)) begin
          err_d = 1'b1;
        end else begin
          data_d  = LBL_W'(depth_q);
          depth_d = depth_q + DW'(1);
        end
      end
      OP_FREE: begin
        if (depth_q != '0 && {1'b0, rreg} == depth_q - DW'(1))
          depth_d = depth_q - DW'(1);
        else
          err_d = 1'b1;
      end
      OP_LABEL: begin
        data_d = lbl_q;
        lbl_d  = lbl_q + LBL_W'(1);
      end
      OP_FLUSH: depth_d = '0;
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      gid_q     <= '0;
      depth_q   <= '0;
      lbl_q     <= '0;
      resp_id   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (advance) begin
        gnt_q <= gnt;
        gid_q <= gid;
      end
      if (state_q == S_GRANT) begin
        depth_q   <= depth_d;
        lbl_q     <= lbl_d;
        resp_id   <= gid_q;
        resp_data <= data_d;
        resp_err  <= err_d;
      end
    end
  end

`ifdef REG_ALLOC_CTRL_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm <= '0;
    else if (state_q == S_GRANT && depth_d > hwm) hwm <= depth_d;
  end
`endif

endmodule

// File: tb/tb_reg_alloc_ctrl.sv
// Randomized + directed bench for reg_alloc_ctrl against a queue-free model.
// Build with REG_ALLOC_CTRL_HWM_EN to also check hwm.
module tb_reg_alloc_ctrl;

  localparam int NQ = 2;
  localparam int NR = 16;
  localparam int LW = 4;

  logic          clk = 0;
  logic          rst_n = 0;
  logic [NQ-1:0] req_valid = '0;
  logic [2*NQ-1:0] req_op = '0;
  logic [4*NQ-1:0] req_reg = '0;
  logic [NQ-1:0] req_ready;
  logic          resp_valid;
  logic          resp_id;
  logic [LW-1:0] resp_data;
  logic          resp_err;
  logic [4:0]    depth;
`ifdef REG_ALLOC_CTRL_HWM_EN
  logic [4:0]    hwm;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_depth, m_lbl, m_ptr, m_hwm;
  int p_v[NQ];
  int p_op[NQ];
  int p_reg[NQ];

  always #5 clk = ~clk;

  reg_alloc_ctrl #(.NUM_REQ(NQ), .NUM_REGS(NR), .LBL_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_reg    (req_reg),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
`ifdef REG_ALLOC_CTRL_HWM_EN
    .hwm        (hwm),
`endif
    .depth      (depth)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req_valid = '0;
    for (int i = 0; i < NQ; i++) p_v[i] = 0;
    m_depth = 0; m_lbl = 0; m_ptr = 0; m_hwm = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic issue(input int who, input int op, input int rg);
    p_v[who] = 1;
    p_op[who] = op;
    p_reg[who] = rg;
    req_op[who*2 +: 2] = 2'(op);
    req_reg[who*4 +: 4] = 4'(rg);
    req_valid[who] = 1'b1;
  endtask

  // Serve one transaction: predict the winner, check grant and response.
  task automatic serve();
    int pick, idx, seen, e_data, e_err;
    pick = -1;
    for (int i = 0; i < NQ; i++) begin
      idx = (m_ptr + i) % NQ;
      if (pick < 0 && p_v[idx] != 0) pick = idx;
    end
    seen = 0;
    for (int c = 0; c < 8 && seen == 0; c++) begin
      step();
      if (req_ready != '0) seen = 1;
      else chk("no_resp_while_wait", int'(resp_valid), 0);
    end
    if (seen == 0) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    chk("grant", int'(req_ready), 1 << pick);
    m_ptr = (pick + 1) % NQ;
    req_valid[pick] = 1'b0;
    p_v[pick] = 0;
    e_data = 0;
    e_err = 0;
    case (p_op[pick])
      0: if (m_depth == NR) e_err = 1;
         else begin e_data = m_depth; m_depth++; end
      1: if (m_depth > 0 && p_reg[pick] == m_depth - 1) m_depth--;
         else e_err = 1;
      2: begin e_data = m_lbl; m_lbl = (m_lbl + 1) % (1 << LW); end
      default: m_depth = 0;
    endcase
    if (m_depth > m_hwm) m_hwm = m_depth;
    step();
    chk("resp_valid", int'(resp_valid), 1);
    chk("resp_id", int'(resp_id), pick);
    chk("resp_data", int'(resp_data), e_data);
    chk("resp_err", int'(resp_err), e_err);
    chk("depth", int'(depth), m_depth);
`ifdef REG_ALLOC_CTRL_HWM_EN
    chk("hwm", int'(hwm), m_hwm);
`endif
    step();
    chk("resp_pulse", int'(resp_valid), 0);
    chk("resp_hold", int'(resp_data), e_data);
  endtask

  initial begin
    do_reset();
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_rvalid", int'(resp_valid), 0);
    chk("rst_id", int'(resp_id), 0);
    chk("rst_data", int'(resp_data), 0);
    chk("rst_err", int'(resp_err), 0);
    chk("rst_depth", int'(depth), 0);

    // Three allocations from requester 0
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 0);
      serve();
    end
    chk("alloc3_depth", int'(depth), 3);

    // Out-of-order free rejected, top-of-stack free accepted
    issue(0, 1, 1); serve();
    issue(0, 1, 2); serve();
    chk("free_depth", int'(depth), 2);

    // Fill to overflow, then flush
    for (int i = 0; i < 15; i++) begin
      issue(1, 0, 0);
      serve();
    end
    chk("full_depth", int'(depth), NR);
    chk("full_err", int'(resp_err), 1);
    issue(0, 3, 0); serve();
    chk("flush_depth", int'(depth), 0);
`ifdef REG_ALLOC_CTRL_HWM_EN
    chk("hwm_after_flush", int'(hwm), NR);
`endif

    // Both requesters contending: grants alternate
    do_reset();
    issue(0, 0, 0);
    issue(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      serve();
      if (p_v[0] == 0) issue(0, 0, 0);
      if (p_v[1] == 0) issue(1, 0, 0);
    end
    req_valid = '0;
    p_v[0] = 0; p_v[1] = 0;
    chk("rr_depth", int'(depth), 4);

    // Label counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      issue(i % 2, 2, 0);
      serve();
    end

    // Reset during GRANT aborts the ALLOC
    do_reset();
    issue(0, 0, 0);
    step();
    chk("abort_grant", int'(req_ready), 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_resp", int'(resp_valid), 0);
    end
    chk("abort_depth", int'(depth), 0);

    // Randomized mix
    for (int t = 0; t < 300; t++) begin
      for (int r = 0; r < NQ; r++) begin
        if (p_v[r] == 0 && $urandom_range(0, 3) != 0) begin
          int op, rg;
          op = $urandom_range(0, 9);
          op = (op < 4) ? 0 : (op < 7) ? 1 : (op < 9) ? 2 : 3;
          rg = ($urandom_range(0, 1) != 0) ? ((m_depth + 15) % 16)
                                           : int'($urandom_range(0, 15));
          issue(r, op, rg);
        end
      end
      if (p_v[0] != 0 || p_v[1] != 0) serve();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_alloc_ctrl.md
REG_ALLOC_CTRL -- requirements
Module: reg_alloc_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_REQ, 2, number of requesters; NUM_REGS, 16, register pool depth (power of 2, >=4); LBL_W, 16, label counter width.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port req_valid  input  NUM_REQ  per-requester request strobe, held until accepted.
REQ-005 Port req_op  input  2*NUM_REQ  per-requester opcode: ALLOC=0, FREE=1, LABEL=2, FLUSH=3.
REQ-006 Port req_reg  input  clog2(NUM_REGS)*NUM_REQ  register index to free (FREE only).
REQ-007 Port req_ready  output  NUM_REQ  one-hot grant; high for exactly one cycle when a request is accepted.
REQ-008 Port resp_valid  output  1  one-cycle response strobe.
REQ-009 Port resp_id  output  clog2(NUM_REQ)  requester the response belongs to.
REQ-010 Port resp_data  output  LBL_W  allocated register index (zero-extended) or label value.
REQ-011 Port resp_err  output  1  request rejected; state unchanged.
REQ-012 Port depth  output  clog2(NUM_REGS)+1  registers currently allocated.

Function
REQ-013 Pool SHALL be strictly LIFO: ALLOC returns index equal to depth, then depth increments.
REQ-014 ALLOC with depth == NUM_REGS SHALL respond resp_err=1, resp_data=0, depth unchanged.
REQ-015 FREE SHALL succeed only if req_reg == depth-1; depth then decrements; otherwise (incl. depth==0) resp_err=1, no change.
REQ-016 LABEL SHALL return current label counter then increment it; wrap from 2^LBL_W-1 to 0 without error.
REQ-017 FLUSH SHALL set depth to 0, keep label counter, respond resp_data=0, resp_err=0.
REQ-018 FSM states IDLE, GRANT, RESP; IDLE->GRANT when any req_valid; GRANT->RESP always (req_ready pulsed, operation executed); RESP->IDLE always (resp_valid pulsed).
REQ-019 Latency: req_ready one cycle after req_valid sampled in IDLE; resp_valid the following cycle; max throughput one request per 3 cycles.
REQ-020 Arbitration SHALL be round-robin; priority pointer advances to the requester after the one granted; after reset requester 0 has priority.
REQ-021 Simultaneous valid requests SHALL be served one per transaction; ungranted requesters keep req_valid asserted and are served in later transactions.
REQ-022 Requester dropping req_valid before grant SHALL be ignored; arbitration re-evaluated in IDLE only.
REQ-023 resp_data, resp_id, resp_err SHALL hold their values until the next response.

Reset
REQ-024 On rst_n low: FSM=IDLE, depth=0, label counter=0, priority pointer=0, req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
REQ-025 Reset mid-transaction SHALL abort it; no response is produced for the aborted request.

Configuration
REQ-026 Macro REG_ALLOC_CTRL_HWM_EN SHALL, when defined, add output hwm (clog2(NUM_REGS)+1 bits) holding maximum depth since reset, not cleared by FLUSH, reset to 0.
REQ-027 Without REG_ALLOC_CTRL_HWM_EN the hwm port and its register SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package reg_alloc_pkg SHALL hold the opcode enum, FSM state enum and default parameter constants.
REQ-029 Round-robin arbitration SHALL be a sub-module rr_arbiter (req vector, advance strobe -> one-hot grant).

Verification
REQ-030 Reset, requester 0 issues 3 ALLOC -> resp_data 0,1,2; depth=3.
REQ-031 depth=3, FREE reg 1 -> resp_err=1, depth=3; FREE reg 2 -> resp_err=0, depth=2.
REQ-032 NUM_REGS=16, 17 ALLOC -> 17th resp_err=1, depth=16; with HWM_EN hwm=16, stays 16 after FLUSH (depth=0).
REQ-033 Both requesters hold ALLOC valid from reset -> grants alternate 0,1,0,1; indices 0,1,2,3 with matching resp_id.
REQ-034 LBL_W=4, 17 LABEL requests -> values 0..15 then 0, no errors.
REQ-035 rst_n asserted in GRANT of an ALLOC -> no resp_valid, depth=0 after reset release.
